// File: rtl/mips_branch_pkg.sv
// Shared definitions for the branch resolve unit: condition codes and
// flush state machine encoding.
package mips_branch_pkg;

    // Branch/jump condition codes carried on the 3-bit cond field.
    localparam logic [2:0] COND_BEZ  = 3'b000;
    localparam logic [2:0] COND_BNE  = 3'b001;
    localparam logic [2:0] COND_JMP  = 3'b010;
    localparam logic [2:0] COND_BEQ  = 3'b011;
    localparam logic [2:0] COND_BLTZ = 3'b100;
    localparam logic [2:0] COND_BGEZ = 3'b101;
    localparam logic [2:0] COND_BGTZ = 3'b110;
    localparam logic [2:0] COND_NOP  = 3'b111;

    // Flush state machine encoding. Two bits leave spare codes; any code
    // other than ST_FLUSH is treated as idle.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluator. Sign-sensitive
// conditions look only at reg1's sign bit and zero-ness, which is the
// signed comparison against zero.
module branch_cond_eval
    import mips_branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_cond,
    input  logic [DATA_W-1:0] i_reg1,
    input  logic [DATA_W-1:0] i_reg2,
    output logic              o_taken
);

    logic w_reg1_zero;
    logic w_reg1_neg;

    assign w_reg1_zero = (i_reg1 == '0);
    assign w_reg1_neg  = i_reg1[DATA_W-1];

    // Decode the condition code into the taken decision.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        o_taken = 1'b0;
        case (i_cond)
            COND_BEZ:  o_taken = w_reg1_zero;
            COND_BNE:  o_taken = (i_reg1 != i_reg2);
            COND_JMP:  o_taken = 1'b1;
            COND_BEQ:  o_taken = (i_reg1 == i_reg2);
            COND_BLTZ: o_taken = w_reg1_neg;
            COND_BGEZ: o_taken = ~w_reg1_neg;
            COND_BGTZ: o_taken = ~w_reg1_neg & ~w_reg1_zero;
            COND_NOP:  o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates the branch condition, computes the target,
// registers the result with a one-cycle valid pulse, squashes wrong-path
// fetches for FLUSH_CYCLES cycles after a taken branch, and keeps
// saturating taken/resolved statistics.
module branch_resolve_unit
    import mips_branch_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              operands_ready,
    input  logic [2:0]        cond,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] offset,
    output logic              res_valid,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    output logic              flush,
    output logic              stall,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  resolved_cnt
);

    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        r_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic              r_res_valid;
    logic              r_res_taken;
    logic [ADDR_W-1:0] r_res_target;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_resolved_cnt;

    logic              w_idle;
    logic              w_resolve;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .i_cond  (cond),
        .i_reg1  (reg1),
        .i_reg2  (reg2),
        .o_taken (w_taken)
    );

    // Spare state codes behave as idle, so the machine recovers by itself.
    assign w_idle    = (r_state != ST_FLUSH);
    assign w_resolve = in_valid & operands_ready & w_idle;
    assign w_target  = pc_in + offset;

    assign stall        = in_valid & ~operands_ready & w_idle;
    assign flush        = (r_state == ST_FLUSH);
    assign res_valid    = r_res_valid;
    assign res_taken    = r_res_taken;
    assign res_target   = r_res_target;
    assign taken_cnt    = r_taken_cnt;
    assign resolved_cnt = r_resolved_cnt;

    // Flush FSM: a taken resolve enters FLUSH; the counter runs down to zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else if (w_idle) begin
            if (w_resolve && w_taken) begin
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FC_LAST;
            end else begin
                r_state <= ST_IDLE;
            end
        end else if (r_flush_cnt == '0) begin
            r_state <= ST_IDLE;
        end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Result register: valid pulses for one cycle, taken/target hold until
    // the next resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid  <= 1'b0;
            r_res_taken  <= 1'b0;
            r_res_target <= '0;
        end else begin
            r_res_valid <= w_resolve;
            if (w_resolve) begin
                r_res_taken  <= w_taken;
                r_res_target <= w_target;
            end
        end
    end

    // Saturating statistics counters, bumped once per resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt    <= '0;
            r_resolved_cnt <= '0;
        end else if (w_resolve) begin
            if (r_resolved_cnt != CNT_MAX) begin
                r_resolved_cnt <= r_resolved_cnt + 1'b1;
            end
            if (w_taken && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised successor to the pipeline's branch condition checker. It resolves eight branch/jump conditions on DATA_W-bit operands and computes the branch target. It registers the taken/target result with a valid pulse and runs a flush state machine that squashes wrong-path instructions for FLUSH_CYCLES cycles. It sits between the ID/EX operand-forwarding logic and the PC/IF-ID control, and also holds saturating branch statistics counters.

Parameters:
DATA_W, 32, operand width in bits
ADDR_W, 32, PC/target width in bits
FLUSH_CYCLES, 2, cycles flush stays asserted after a taken branch (legal range >= 1)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  branch-type instruction present this cycle
operands_ready  in  1  forwarded operands are valid this cycle
cond  in  3  condition code (see Behaviour)
reg1  in  DATA_W  first operand (rs)
reg2  in  DATA_W  second operand (rt)
pc_in  in  ADDR_W  PC of the branch instruction
offset  in  ADDR_W  target offset, already sign-extended
res_valid  out  1  one-cycle pulse: result registered
res_taken  out  1  registered taken flag
res_target  out  ADDR_W  registered target
flush  out  1  squash IF/ID stages
stall  out  1  combinational; hold the pipeline
taken_cnt  out  CNT_W  number of taken resolutions
resolved_cnt  out  CNT_W  number of total resolutions

Behaviour:
- Condition codes; operands are compared signed where a sign is involved:
  - 000 BEZ: reg1==0
  - 001 BNE: reg1!=reg2
  - 010 JMP: always taken
  - 011 BEQ: reg1==reg2
  - 100 BLTZ: reg1<0
  - 101 BGEZ: reg1>=0
  - 110 BGTZ: reg1>0
  - 111 NOP: never taken
- Target: pc_in + offset, truncated to ADDR_W; wraps modulo 2^ADDR_W.
- Reset (asynchronous, any time, including mid-flush): state=IDLE, flush counter=0, res_valid=0, res_taken=0, res_target=0, flush=0, taken_cnt=0, resolved_cnt=0. stall follows its combinational equation.
- stall = in_valid & ~operands_ready & (state==IDLE). No resolution occurs while stall=1. Inputs must be held by the upstream stage.
- A resolve event is in_valid & operands_ready & state==IDLE. It is seen in cycle N; outputs change at edge N+1 (latency 1):
  - res_valid=1 for exactly one cycle.
  - res_taken and res_target are loaded and hold until the next resolve event. res_target is loaded even when not taken.
  - resolved_cnt is incremented.
  - If taken: taken_cnt is incremented, flush=1, flush counter=FLUSH_CYCLES-1, state goes to FLUSH.
- States:
  - IDLE: as above. A not-taken resolve stays in IDLE, so back-to-back resolves every cycle are legal.
  - FLUSH: flush=1. in_valid is ignored (wrong-path), with no stall, no res_valid and no counting. If counter==0, flush drops at the next edge and state returns to IDLE. Otherwise the counter decrements.
- flush is high for exactly FLUSH_CYCLES consecutive cycles per taken branch.
- An input presented in the cycle flush deasserts (back in IDLE) is resolved normally.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Unknown states decode to IDLE.

Decomposition:
- Shared package mips_branch_pkg holds the 3-bit cond localparams (COND_BEZ..COND_NOP) and the state encoding (ST_IDLE, ST_FLUSH).
- One natural sub-module is branch_cond_eval. It is purely combinational: cond, reg1, reg2 -> taken, parametrised on DATA_W.
- Target adder, flush FSM and counters stay in the top module.

Test Plan:
- Reset with rst pulsed high mid-cycle during FLUSH -> all outputs 0 immediately (asynchronous); resume in IDLE; counters 0.
- cond=001, reg1=5, reg2=5, pc_in=0x100, offset=0x10 -> next cycle res_valid=1, res_taken=0, res_target=0x110, flush=0; resolved_cnt=1, taken_cnt=0.
- cond=100, reg1=0xFFFFFFFF (-1), FLUSH_CYCLES=2 -> res_taken=1, flush high exactly 2 cycles. in_valid asserted during those cycles produces no res_valid. in_valid asserted in the following cycle resolves normally.
- in_valid=1, operands_ready=0 for 3 cycles, then 1 (cond=000, reg1=0) -> stall=1 for 3 cycles, then a single res_valid with res_taken=1.
- pc_in=0xFFFFFFF0, offset=0x20, cond=010 -> res_target=0x00000010 (wrap), res_taken=1.
- CNT_W=4; issue 17 taken JMPs separated by their flushes -> taken_cnt and resolved_cnt saturate at 15.
